// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, cause codes and counter width for the trap sequencer
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        HALT
    } state_t;

    localparam logic [31:0] CAUSE_IADDR_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;

    localparam int CNT_W = 3;

endpackage

// File: rtl/trap_cause_enc.sv
// trap_cause_enc: priority encoder from trap request lines to {request, mcause code}
module trap_cause_enc
    import trap_pkg::*;
(
    input  logic        initiate_illinst,
    input  logic        initiate_misaligned,
    input  logic        misaligned_mem,
    input  logic        XB_is_store,
    input  logic        XB_ecall,
    input  logic        XB_ebreak,
    output logic        req,
    output logic [31:0] cause
);

    // highest-priority source picks the cause; bit 31 stays 0 since there are no interrupts
    always_comb begin
        req   = initiate_illinst | initiate_misaligned | XB_ecall | XB_ebreak;
        cause = initiate_illinst    ? CAUSE_ILLEGAL :
                initiate_misaligned ? (!misaligned_mem ? CAUSE_IADDR_MISALIGNED :
                                       XB_is_store     ? CAUSE_STORE_MISALIGNED :
                                                         CAUSE_LOAD_MISALIGNED) :
                XB_ebreak           ? CAUSE_BREAKPOINT :
                XB_ecall            ? CAUSE_ECALL_M : '0;
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer producing redirect, timed flush, mcause write and nested-trap lockup
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        initiate_illinst,
    input  logic        initiate_misaligned,
    input  logic        misaligned_mem,
    input  logic        XB_is_store,
    input  logic        XB_ecall,
    input  logic        XB_ebreak,
    input  logic        XB_mret,
    input  logic [31:0] csr_mepc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        mcause_we,
    output logic [31:0] mcause_value,
    output logic        in_handler,
    output logic        halted
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              req;
    logic [31:0]       cause;

    trap_cause_enc u_enc (
        .initiate_illinst    (initiate_illinst),
        .initiate_misaligned (initiate_misaligned),
        .misaligned_mem      (misaligned_mem),
        .XB_is_store         (XB_is_store),
        .XB_ecall            (XB_ecall),
        .XB_ebreak           (XB_ebreak),
        .req                 (req),
        .cause               (cause)
    );

    // trap/MRET sequencing: strobes last one cycle, flush spans the counter, HALT is sticky until reset
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= TRAP_VECTOR;
            flush          <= 1'b0;
            mcause_we      <= 1'b0;
            mcause_value   <= '0;
            in_handler     <= 1'b0;
            halted         <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            mcause_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && in_handler) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        flush  <= 1'b1;
                    end else if (req) begin
                        state          <= FLUSH;
                        cnt            <= CNT_LOAD;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= TRAP_VECTOR;
                        mcause_we      <= 1'b1;
                        mcause_value   <= cause;
                        in_handler     <= 1'b1;
                        flush          <= 1'b1;
                    end else if (XB_mret) begin
                        state          <= FLUSH;
                        cnt            <= CNT_LOAD;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= csr_mepc;
                        in_handler     <= 1'b0;
                        flush          <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    flush  <= 1'b1;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table vectors, directed corner sequences and a randomized run against a behavioural model
module tb_trap_ctrl;

    localparam logic [31:0] TV = 32'h0000_0000;
    localparam int          FC = 2;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        ill = 1'b0, mis = 1'b0, mem = 1'b0, st = 1'b0;
    logic        ecall = 1'b0, ebreak = 1'b0, mret = 1'b0;
    logic [31:0] mepc = '0;
    logic        redirect_valid, flush, mcause_we, in_handler, halted;
    logic [31:0] redirect_pc, mcause_value;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
        .clk                 (clk),
        .resetb              (resetb),
        .initiate_illinst    (ill),
        .initiate_misaligned (mis),
        .misaligned_mem      (mem),
        .XB_is_store         (st),
        .XB_ecall            (ecall),
        .XB_ebreak           (ebreak),
        .XB_mret             (mret),
        .csr_mepc            (mepc),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .flush               (flush),
        .mcause_we           (mcause_we),
        .mcause_value        (mcause_value),
        .in_handler          (in_handler),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ill, mis, mem, st, ecall, ebreak, mret;
        logic [31:0] mepc;
        logic        rv;
        logic [31:0] pc;
        logic        mwe;
        logic [31:0] cause;
        logic        inh;
    } vec_t;

    vec_t vecs[8];

    // behavioural model state
    int          m_left;
    logic        m_inh, m_halt, m_rv, m_mwe;
    logic [31:0] m_pc, m_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic rv, input logic [31:0] pc, input logic fl,
                           input logic mwe, input logic [31:0] cause, input logic inh, input logic hlt);
        chk({name, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({name, ".redirect_pc"}, redirect_pc, pc);
        chk({name, ".flush"}, 32'(flush), 32'(fl));
        chk({name, ".mcause_we"}, 32'(mcause_we), 32'(mwe));
        chk({name, ".mcause_value"}, mcause_value, cause);
        chk({name, ".in_handler"}, 32'(in_handler), 32'(inh));
        chk({name, ".halted"}, 32'(halted), 32'(hlt));
    endtask

    task automatic clr_in();
        {ill, mis, mem, st, ecall, ebreak, mret} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0;
        clr_in();
        @(negedge clk);
        resetb = 1'b1;
        m_left = 0; m_inh = 0; m_halt = 0; m_rv = 0; m_mwe = 0; m_pc = TV; m_cause = 0;
    endtask

    function automatic logic [31:0] ref_cause();
        if (ill) return 32'd2;
        if (mis && !mem) return 32'd0;
        if (mis && !st) return 32'd4;
        if (mis) return 32'd6;
        if (ebreak) return 32'd3;
        return 32'd11;
    endfunction

    // advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        m_rv = 0;
        m_mwe = 0;
        if (m_halt) begin
        end else if (m_left > 0) begin
            m_left--;
        end else if ((ill | mis | ecall | ebreak) && m_inh) begin
            m_halt = 1;
        end else if (ill | mis | ecall | ebreak) begin
            m_rv = 1; m_mwe = 1; m_pc = TV; m_cause = ref_cause(); m_inh = 1; m_left = FC;
        end else if (mret) begin
            m_rv = 1; m_pc = mepc; m_inh = 0; m_left = FC;
        end
    endtask

    initial begin
        vecs[0] = '{"illinst",      1,0,0,0,0,0,0, 32'h0,   1, TV,      1, 32'd2,  1};
        vecs[1] = '{"iaddr_mis",    0,1,0,1,1,1,0, 32'h0,   1, TV,      1, 32'd0,  1};
        vecs[2] = '{"load_mis",     0,1,1,0,1,0,0, 32'h0,   1, TV,      1, 32'd4,  1};
        vecs[3] = '{"store_mis",    0,1,1,1,1,1,0, 32'h0,   1, TV,      1, 32'd6,  1};
        vecs[4] = '{"ebreak",       0,0,0,0,1,1,0, 32'h0,   1, TV,      1, 32'd3,  1};
        vecs[5] = '{"ecall",        0,0,0,0,1,0,0, 32'h0,   1, TV,      1, 32'd11, 1};
        vecs[6] = '{"mret_idle",    0,0,0,0,0,0,1, 32'h200, 1, 32'h200, 0, 32'd0,  0};
        vecs[7] = '{"ebreak_mret",  0,0,0,0,0,1,1, 32'h300, 1, TV,      1, 32'd3,  1};

        do_reset();
        chk_all("reset", 0, TV, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            do_reset();
            {ill, mis, mem, st, ecall, ebreak, mret} =
                {vecs[i].ill, vecs[i].mis, vecs[i].mem, vecs[i].st, vecs[i].ecall, vecs[i].ebreak, vecs[i].mret};
            mepc = vecs[i].mepc;
            step();
            chk_all(vecs[i].name, vecs[i].rv, vecs[i].pc, 1, vecs[i].mwe, vecs[i].cause, vecs[i].inh, 0);
        end

        // illinst: strobes one cycle, flush exactly two cycles
        do_reset();
        ill = 1;
        step();
        chk_all("ill_c0", 1, TV, 1, 1, 2, 1, 0);
        @(negedge clk); clr_in();
        step();
        chk_all("ill_c1", 0, TV, 1, 0, 2, 1, 0);
        step();
        chk_all("ill_c2", 0, TV, 0, 0, 2, 1, 0);

        // store misaligned beats ecall; illinst during FLUSH is ignored
        do_reset();
        mis = 1; mem = 1; st = 1; ecall = 1;
        step();
        chk_all("st_c0", 1, TV, 1, 1, 6, 1, 0);
        @(negedge clk); clr_in(); ill = 1;
        step();
        chk_all("st_c1", 0, TV, 1, 0, 6, 1, 0);
        step();
        chk_all("st_c2", 0, TV, 0, 0, 6, 1, 0);
        @(negedge clk); clr_in();

        // MRET inside handler returns to mepc
        mepc = 32'h0000_0104; mret = 1;
        step();
        chk_all("mret_c0", 1, 32'h104, 1, 0, 6, 0, 0);
        @(negedge clk); clr_in();
        step();
        chk_all("mret_c1", 0, 32'h104, 1, 0, 6, 0, 0);
        step();
        chk_all("mret_c2", 0, 32'h104, 0, 0, 6, 0, 0);

        // trap, then nested illinst after FLUSH locks up
        @(negedge clk); ecall = 1;
        step();
        @(negedge clk); clr_in();
        step(); step();
        @(negedge clk); ill = 1;
        step();
        chk_all("halt_entry", 0, TV, 1, 0, 11, 1, 1);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            {ill, ecall, mret} = 3'($urandom);
            mepc = $urandom;
            step();
            chk("halt_hold.halted", 32'(halted), 1);
            chk("halt_hold.flush", 32'(flush), 1);
            chk("halt_hold.redirect_valid", 32'(redirect_valid), 0);
        end
        do_reset();
        chk_all("halt_reset", 0, TV, 0, 0, 0, 0, 0);

        // async reset during the second FLUSH cycle, then a clean ecall
        ecall = 1;
        step();
        @(negedge clk); clr_in();
        @(posedge clk);
        @(negedge clk);
        resetb = 0;
        #1;
        chk_all("async_rst", 0, TV, 0, 0, 0, 0, 0);
        @(negedge clk); resetb = 1;
        @(negedge clk); ecall = 1;
        step();
        chk_all("post_rst_ecall", 1, TV, 1, 1, 11, 1, 0);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (m_halt && $urandom_range(3) == 0) begin
                resetb = 0;
                #1;
                chk_all("rand_rst", 0, TV, 0, 0, 0, 0, 0);
                clr_in();
                @(negedge clk);
                resetb = 1;
                m_left = 0; m_inh = 0; m_halt = 0; m_rv = 0; m_mwe = 0; m_pc = TV; m_cause = 0;
                continue;
            end
            ill    = ($urandom_range(15) == 0);
            mis    = ($urandom_range(11) == 0);
            mem    = $urandom_range(1);
            st     = $urandom_range(1);
            ecall  = ($urandom_range(9) == 0);
            ebreak = ($urandom_range(11) == 0);
            mret   = ($urandom_range(2) == 0);
            mepc   = $urandom & 32'hFFFF_FFFC;
            model_edge();
            step();
            chk_all("rand", m_rv, m_pc, m_halt || (m_left > 0), m_mwe, m_cause, m_inh, m_halt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
